// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction-fetch PC sequencer with i-cache refill handshake (optional FETCH_PERF_CNT_EN counters)
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_hit,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        mem_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic        if_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        icache_fill_en
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] miss_count,
    output logic [15:0] stall_cycles
`endif
);

    // Clearing the low bits of the PC gives the first word of its cache line.
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS) - 32'd1);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_MISS_REQ = 2'd1,
        S_REFILL   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_mem_addr;
    logic [31:0] w_mem_addr_nxt;
    logic        r_redir_pending;
    logic        w_redir_pending_nxt;
    logic [31:0] r_redir_target;
    logic [31:0] w_redir_target_nxt;

    assign pc             = r_pc;
    assign pc_plus1       = r_pc + 32'd1;
    assign mem_addr       = r_mem_addr;
    assign mem_req        = (r_state == S_MISS_REQ);
    assign icache_fill_en = (r_state == S_REFILL);
    assign if_valid       = (r_state == S_FETCH) && icache_hit && !stall && !branch_taken;

    // Next-state, next-PC and redirect bookkeeping; a branch always wins in FETCH.
    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_mem_addr_nxt      = r_mem_addr;
        w_redir_pending_nxt = r_redir_pending;
        w_redir_target_nxt  = r_redir_target;
        case (r_state)
            S_FETCH: begin
                if (branch_taken) begin
                    w_pc_nxt = branch_target;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (icache_hit) begin
                    w_pc_nxt = r_pc + 32'd1;
                end else begin
                    w_mem_addr_nxt = r_pc & LINE_MASK;
                    w_state_nxt    = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                // The request runs to completion; a branch is remembered for later.
                if (branch_taken) begin
                    w_redir_pending_nxt = 1'b1;
                    w_redir_target_nxt  = branch_target;
                end
                if (mem_ack) begin
                    w_state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                // A branch seen in this very cycle is newer than any pending one.
                if (branch_taken) begin
                    w_pc_nxt = branch_target;
                end else if (r_redir_pending) begin
                    w_pc_nxt = r_redir_target;
                end
                w_redir_pending_nxt = 1'b0;
                w_state_nxt         = S_FETCH;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // State, PC and refill-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_FETCH;
            r_pc            <= RESET_PC;
            r_mem_addr      <= 32'd0;
            r_redir_pending <= 1'b0;
            r_redir_target  <= 32'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_mem_addr      <= w_mem_addr_nxt;
            r_redir_pending <= w_redir_pending_nxt;
            r_redir_target  <= w_redir_target_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_miss_count;
    logic [15:0] r_stall_cycles;
    logic        w_miss_start;
    logic        w_busy;

    assign w_miss_start = (r_state == S_FETCH) && (w_state_nxt == S_MISS_REQ);
    assign w_busy       = (r_state == S_MISS_REQ) || (r_state == S_REFILL);
    assign miss_count   = r_miss_count;
    assign stall_cycles = r_stall_cycles;

    // Saturating miss and miss-penalty counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_count   <= 16'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (w_miss_start && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
            if (w_busy && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking random + directed bench for fetch_controller
module tb_fetch_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_hit = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        if_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        icache_fill_en;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] miss_count;
    logic [15:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    fetch_controller #(
        .RESET_PC  (RST_PC),
        .LINE_WORDS(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icache_hit    (icache_hit),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_ack       (mem_ack),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .if_valid      (if_valid),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .icache_fill_en(icache_fill_en)
`ifdef FETCH_PERF_CNT_EN
        ,
        .miss_count    (miss_count),
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the fetch unit is either streaming, waiting for a line, or writing a line.
    logic [31:0] m_pc       = RST_PC;
    logic [31:0] m_line     = 32'd0;
    bit          m_waiting  = 1'b0;
    bit          m_filling  = 1'b0;
    bit          m_redir    = 1'b0;
    logic [31:0] m_redir_to = 32'd0;
    int          m_misses   = 0;
    int          m_busy_cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_line = 32'd0; m_waiting = 1'b0; m_filling = 1'b0;
            m_redir = 1'b0; m_redir_to = 32'd0; m_misses = 0; m_busy_cyc = 0;
        end else if (m_filling) begin
            m_busy_cyc = m_busy_cyc + 1;
            m_filling = 1'b0;
            if (branch_taken) m_pc = branch_target;
            else if (m_redir) m_pc = m_redir_to;
            m_redir = 1'b0;
        end else if (m_waiting) begin
            m_busy_cyc = m_busy_cyc + 1;
            if (branch_taken) begin
                m_redir = 1'b1;
                m_redir_to = branch_target;
            end
            if (mem_ack) begin
                m_waiting = 1'b0;
                m_filling = 1'b1;
            end
        end else begin
            if (branch_taken) m_pc = branch_target;
            else if (stall) m_pc = m_pc;
            else if (icache_hit) m_pc = m_pc + 32'd1;
            else begin
                m_line = {m_pc[31:2], 2'b00};
                m_waiting = 1'b1;
                m_misses = m_misses + 1;
            end
        end
    end

    // Compare every cycle on the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc", pc, m_pc);
            chk("pc_plus1", pc_plus1, m_pc + 32'd1);
            chk("mem_req", {31'd0, mem_req}, {31'd0, m_waiting});
            chk("icache_fill_en", {31'd0, icache_fill_en}, {31'd0, m_filling});
            chk("mem_addr", mem_addr, m_line);
            chk("if_valid", {31'd0, if_valid},
                {31'd0, !m_waiting && !m_filling && icache_hit && !stall && !branch_taken});
`ifdef FETCH_PERF_CNT_EN
            chk("miss_count", {16'd0, miss_count}, (m_misses > 65535) ? 32'hFFFF : 32'(m_misses));
            chk("stall_cycles", {16'd0, stall_cycles}, (m_busy_cyc > 65535) ? 32'hFFFF : 32'(m_busy_cyc));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic h, input logic s, input logic b, input logic [31:0] t, input logic a);
        icache_hit = h; stall = s; branch_taken = b; branch_target = t; mem_ack = a;
    endtask

    initial begin
        // Reset state
        set_in(0, 0, 0, 32'd0, 0);
        rst_n = 1'b0;
        cyc();
        chk_on = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst pc", pc, 32'h10);
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst fill", {31'd0, icache_fill_en}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);

        // Reset then hits
        cyc();
        rst_n = 1'b1;
        set_in(1, 0, 0, 32'd0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hit pc", pc, 32'h10 + 32'(i));
            if (i < 4) chk("hit if_valid", {31'd0, if_valid}, 32'd1);
            if (i < 4) cyc();
        end

        // Miss at 0x23, ack after 5 cycles of request
        cyc();
        set_in(1, 0, 1, 32'h23, 0);
        cyc();
        set_in(0, 0, 0, 32'd0, 0);
        @(negedge clk);
        chk("miss if_valid", {31'd0, if_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("miss mem_req", {31'd0, mem_req}, 32'd1);
        chk("miss mem_addr", mem_addr, 32'h20);
        for (int i = 0; i < 4; i++) cyc();
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("refill fill", {31'd0, icache_fill_en}, 32'd1);
        chk("refill mem_req", {31'd0, mem_req}, 32'd0);
        icache_hit = 1'b1;
        cyc();
        @(negedge clk);
        chk("refetch pc", pc, 32'h23);
        chk("refetch if_valid", {31'd0, if_valid}, 32'd1);
        cyc();
        @(negedge clk);
        chk("after refetch pc", pc, 32'h24);

        // Branch during miss
        icache_hit = 1'b0;
        cyc();
        set_in(0, 0, 1, 32'h80, 0);
        cyc();
        set_in(0, 0, 0, 32'd0, 0);
        cyc();
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("br-miss fill", {31'd0, icache_fill_en}, 32'd1);
        cyc();
        @(negedge clk);
        chk("br-miss pc", pc, 32'h80);

        // Branch beats stall and miss
        set_in(0, 1, 1, 32'h40, 0);
        @(negedge clk);
        chk("bsm if_valid", {31'd0, if_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("bsm pc", pc, 32'h40);
        chk("bsm mem_req", {31'd0, mem_req}, 32'd0);

        // Wrap
        set_in(0, 0, 1, 32'hFFFF_FFFF, 0);
        cyc();
        set_in(1, 0, 0, 32'd0, 0);
        @(negedge clk);
        chk("wrap pc_plus1", pc_plus1, 32'd0);
        cyc();
        @(negedge clk);
        chk("wrap pc", pc, 32'd0);

        // Reset mid-miss
        icache_hit = 1'b0;
        cyc();
        @(negedge clk);
        chk("rm mem_req before", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm mem_req", {31'd0, mem_req}, 32'd0);
        chk("rm pc", pc, 32'h10);
`ifdef FETCH_PERF_CNT_EN
        chk("rm miss_count", {16'd0, miss_count}, 32'd0);
        chk("rm stall_cycles", {16'd0, stall_cycles}, 32'd0);
`endif
        cyc();
        rst_n = 1'b1;
        set_in(1, 0, 0, 32'd0, 1);
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rm ack ignored pc", pc, 32'h11);
        chk("rm ack ignored fill", {31'd0, icache_fill_en}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            cyc();
            rst_n = ($urandom_range(0, 499) != 0);
            icache_hit    = ($urandom_range(0, 9) < 7);
            stall         = ($urandom_range(0, 9) < 2);
            branch_taken  = ($urandom_range(0, 9) < 1);
            branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            mem_ack       = ($urandom_range(0, 9) < 3);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
